// File: rtl/thresh_if.sv
// Command/status bundle between the command processor and the threshold DAC sequencer.
// The master side issues VIH/VIL writes; the slave side drives the PWM duties and status.
interface thresh_if;
  logic       wr_vih;
  logic       wr_vil;
  logic [7:0] wdata;
  logic [7:0] VIH;
  logic [7:0] VIL;
  logic       busy;
  logic       settled;
  logic       err;

  modport master (
    output wr_vih, wr_vil, wdata,
    input  VIH, VIL, busy, settled, err
  );

  modport slave (
    input  wr_vih, wr_vil, wdata,
    output VIH, VIL, busy, settled, err
  );
endinterface

// File: rtl/thresh_ctrl.sv
// Dual-PWM threshold sequencer: validates VIH/VIL writes against the minimum gap and
// flags when the RC-filtered thresholds have settled. Define THRESH_RAMP_EN for 1-LSB ramping.
module thresh_ctrl #(
  parameter int SETTLE_CYCLES = 4096,
  parameter int MIN_GAP       = 8
`ifdef THRESH_RAMP_EN
  , parameter int RAMP_DIV    = 256
`endif
) (
  input logic      clk,
  input logic      rst_n,
  thresh_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd2;
`ifdef THRESH_RAMP_EN
  localparam logic [1:0] RAMP   = 2'd1;
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       vih_tgt;
  logic [7:0]       vil_tgt;
  logic [7:0]       vih_q;
  logic [7:0]       vil_q;
  logic             busy_q;
  logic             settled_q;
  logic             err_q;
  logic             wr_vih_q;
  logic             wr_vil_q;
  logic [7:0]       wdata_q;
  logic             accept_vih;
  logic             accept_vil;
  logic             reject;
`ifdef THRESH_RAMP_EN
  logic [DIV_W-1:0] div;
`endif

  // 9-bit compare so that lo + MIN_GAP cannot wrap past 8'hFF
  function automatic logic gap_ok(input logic [7:0] hi, input logic [7:0] lo);
    return {1'b0, hi} >= ({1'b0, lo} + 9'(MIN_GAP));
  endfunction

`ifdef THRESH_RAMP_EN
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction
`endif

  always_comb begin
    accept_vih = wr_vih_q && !wr_vil_q && gap_ok(wdata_q, vil_tgt);
    accept_vil = wr_vil_q && !wr_vih_q && gap_ok(vih_tgt, wdata_q);
    reject     = (wr_vih_q || wr_vil_q) && !accept_vih && !accept_vil;
  end

  // Strobes are captured only while not busy, so writes during busy vanish without error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SETTLE;
      cnt       <= '0;
      vih_tgt   <= 8'hAA;
      vil_tgt   <= 8'h55;
      vih_q     <= 8'hAA;
      vil_q     <= 8'h55;
      busy_q    <= 1'b1;
      settled_q <= 1'b0;
      err_q     <= 1'b0;
      wr_vih_q  <= 1'b0;
      wr_vil_q  <= 1'b0;
      wdata_q   <= 8'h00;
`ifdef THRESH_RAMP_EN
      div       <= '0;
`endif
    end else begin
      err_q    <= 1'b0;
      wr_vih_q <= bus.wr_vih && !busy_q;
      wr_vil_q <= bus.wr_vil && !busy_q;
      wdata_q  <= bus.wdata;
      case (state)
        IDLE: begin
          if (accept_vih || accept_vil) begin
            if (accept_vih) vih_tgt <= wdata_q;
            if (accept_vil) vil_tgt <= wdata_q;
            busy_q    <= 1'b1;
            settled_q <= 1'b0;
`ifdef THRESH_RAMP_EN
            state <= RAMP;
            div   <= '0;
`else
            if (accept_vih) vih_q <= wdata_q;
            if (accept_vil) vil_q <= wdata_q;
            state <= SETTLE;
            cnt   <= '0;
`endif
          end else if (reject) begin
            err_q <= 1'b1;
          end
        end
`ifdef THRESH_RAMP_EN
        RAMP: begin
          if (vih_q == vih_tgt && vil_q == vil_tgt) begin
            state <= SETTLE;
            cnt   <= '0;
            div   <= '0;
          end else if (div == DIV_W'(RAMP_DIV - 1)) begin
            div   <= '0;
            vih_q <= step_toward(vih_q, vih_tgt);
            vil_q <= step_toward(vil_q, vil_tgt);
          end else begin
            div <= div + 1'b1;
          end
        end
`endif
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            settled_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.VIH     = vih_q;
  assign bus.VIL     = vil_q;
  assign bus.busy    = busy_q;
  assign bus.settled = settled_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_thresh_ctrl.sv
// Testbench for thresh_ctrl (default build): directed scenarios plus random writes,
// every cycle compared against a deadline-based reference model of the threshold pair.
module tb_thresh_ctrl;

  localparam int S   = 32;
  localparam int GAP = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thresh_if bus ();

  thresh_ctrl #(.SETTLE_CYCLES(S), .MIN_GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: write requests act one edge after capture; settling ends at a deadline cycle
  logic [7:0] m_vih, m_vil, p_data;
  logic       m_busy, m_settled, m_err, p_vih, p_vil;
  int         deadline;

  task automatic check_output(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    check_output("VIH", bus.VIH, m_vih);
    check_output("VIL", bus.VIL, m_vil);
    check_output("busy", {7'd0, bus.busy}, {7'd0, m_busy});
    check_output("settled", {7'd0, bus.settled}, {7'd0, m_settled});
    check_output("err", {7'd0, bus.err}, {7'd0, m_err});
  endtask

  task automatic model_reset();
    m_vih = 8'hAA; m_vil = 8'h55;
    m_busy = 1'b1; m_settled = 1'b0; m_err = 1'b0;
    p_vih = 1'b0; p_vil = 1'b0; p_data = 8'h00;
    deadline = cyc + S;
  endtask

  task automatic model_edge(input logic s_vih, input logic s_vil, input logic [7:0] d);
    logic n_vih, n_vil;
    n_vih = s_vih && !m_busy;
    n_vil = s_vil && !m_busy;
    m_err = 1'b0;
    if (m_busy) begin
      if (cyc == deadline) begin
        m_busy = 1'b0;
        m_settled = 1'b1;
      end
    end else if (p_vih && p_vil) begin
      m_err = 1'b1;
    end else if (p_vih || p_vil) begin
      if ((p_vih && int'(p_data) >= int'(m_vil) + GAP) ||
          (p_vil && int'(m_vih) >= int'(p_data) + GAP)) begin
        if (p_vih) m_vih = p_data; else m_vil = p_data;
        m_busy = 1'b1;
        m_settled = 1'b0;
        deadline = cyc + S;
      end else begin
        m_err = 1'b1;
      end
    end
    p_vih = n_vih; p_vil = n_vil; p_data = d;
  endtask

  // Drive one cycle of strobes, advance one edge, then compare everything
  task automatic apply_stimulus(input logic s_vih, input logic s_vil, input logic [7:0] d);
    bus.wr_vih = s_vih;
    bus.wr_vil = s_vil;
    bus.wdata  = d;
    @(posedge clk);
    cyc++;
    model_edge(s_vih, s_vil, d);
    #1;
    bus.wr_vih = 1'b0;
    bus.wr_vil = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.wr_vih = 1'b0;
    bus.wr_vil = 1'b0;
    bus.wdata  = 8'h00;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    check_output("rst_VIH", bus.VIH, 8'hAA);
    check_output("rst_VIL", bus.VIL, 8'h55);
    check_output("rst_busy", {7'd0, bus.busy}, 8'd1);
    check_output("rst_settled", {7'd0, bus.settled}, 8'd0);
    rst_n = 1'b1;
    model_reset();

    idle(S - 1);
    check_output("busy_before_settle", {7'd0, bus.busy}, 8'd1);
    idle(1);
    check_output("settled_at_S", {7'd0, bus.settled}, 8'd1);
    idle(2);

    apply_stimulus(1'b0, 1'b1, 8'hA3);
    idle(1);
    check_output("err_gap7", {7'd0, bus.err}, 8'd1);
    idle(1);
    apply_stimulus(1'b0, 1'b1, 8'hA2);
    idle(1);
    check_output("VIL_gap8", bus.VIL, 8'hA2);
    idle(S + 2);

    apply_stimulus(1'b1, 1'b0, 8'hC0);
    idle(1);
    check_output("VIH_C0", bus.VIH, 8'hC0);
    idle(5);
    apply_stimulus(1'b1, 1'b0, 8'hF0);
    idle(S);

    apply_stimulus(1'b1, 1'b1, 8'hD0);
    idle(3);

    apply_stimulus(1'b1, 1'b0, 8'hFF);
    idle(S + 2);
    apply_stimulus(1'b0, 1'b1, 8'hF8);
    idle(2);
    apply_stimulus(1'b0, 1'b1, 8'hF7);
    idle(S + 2);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    idle(S + 2);
    apply_stimulus(1'b1, 1'b0, 8'hFF);
    idle(S + 2);

    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      logic [7:0] d;
      r = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 255));
      else if (r < 2) d = m_vil + 8'($urandom_range(5, 11));
      else d = m_vih - 8'($urandom_range(5, 11));
      if (r < 2)       apply_stimulus(1'b1, 1'b0, d);
      else if (r < 4)  apply_stimulus(1'b0, 1'b1, d);
      else if (r == 4) apply_stimulus(1'b1, 1'b1, d);
      else             idle(1);
    end

    idle(S + 2);
    apply_stimulus(1'b1, 1'b0, 8'hE0);
    idle(10);
    do_reset();
    idle(S + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
